adc_serial_reader: RTL and testbench
====================================

# adc_serial_reader

Serial ADC front end that produces the light-intensity samples consumed by the threshold comparator/counter stage. Drives chip-select and serial clock of an 8-bit serial-output ADC, shifts in one sample MSB-first, presents it on `adc_data`, and issues a one-cycle `sig` strobe per completed conversion. Conversions repeat while `en` is high, spaced by a programmable idle gap.

## Interface
Parameters:
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles; legal range 1..65535.
- `CONV_GAP`, default 100: `clk` cycles spent in GAP after each conversion; legal range 1..65535.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `n_rst`  input  1  reset, asynchronous, active-low.
- `en`  input  1  level; conversions start only while high.
- `adc_sdo`  input  1  ADC serial data; valid during `sclk` low phase.
- `adc_cs_n`  output  1  ADC chip select, active-low, registered.
- `adc_sclk`  output  1  ADC serial clock, idles low, registered.
- `adc_data`  output  8  last completed sample; held between conversions.
- `sig`  output  1  one-cycle strobe: `adc_data` updated this cycle.
- `busy`  output  1  high in every state except IDLE.

## Operation
- States: IDLE, SETUP, SHIFT, DONE, GAP.
- IDLE: `adc_cs_n`=1, `adc_sclk`=0. With `en`=1 at an edge, go to SETUP and drive `adc_cs_n`=0 on the same edge (edge T0).
- SETUP: `adc_cs_n`=0, `adc_sclk`=0 for CLK_DIV cycles, then SHIFT.
- SHIFT: `adc_sclk` toggles every CLK_DIV cycles for 16 half-periods (8 pulses). On each edge that drives `adc_sclk` 0→1, `adc_sdo` is shifted into an internal 8-bit register, MSB first. After the 8th falling edge, go to DONE.
- DONE: `adc_sclk`=0, `adc_cs_n`=0 for CLK_DIV cycles. On exit, `adc_cs_n`=1, the shift register is copied to `adc_data`, and `sig`=1 for exactly one cycle. Go to GAP.
- GAP: `adc_cs_n`=1 for CONV_GAP cycles, then IDLE.
- `en` is sampled only in IDLE. Dropping `en` mid-conversion does not abort the conversion; it completes with `sig` as normal, and the block then stays in IDLE.
- The shift register is internal. `adc_data` never shows partial samples.
- `busy` = (state != IDLE).

## Timing
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `adc_data`=8'h00, `sig`=0, `busy`=0. State is IDLE and all counters are 0.
- Rising edges of `adc_sclk` at T0+CLK_DIV·(2k+1), falling edges at T0+CLK_DIV·(2k+2), k=0..7.
- Bit 7−k is sampled at edge T0+CLK_DIV·(2k+1).
- At edge T0+17·CLK_DIV: `adc_cs_n`→1, `adc_data` updated, `sig`→1. `sig` returns to 0 at the next edge.
- Re-entry to IDLE occurs at T0+17·CLK_DIV+CONV_GAP.
- With `en` held high, the conversion period is 17·CLK_DIV+CONV_GAP+1 cycles; with defaults, 169 cycles.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), the partial sample is discarded, and no `sig` is issued. The first conversion after release starts no earlier than the first edge with `en`=1.
- `adc_sdo` is assumed synchronous to `clk` (same board clock domain). No synchronizer is included.

## Test plan
- Defaults, `en`=1, ADC model returns 8'hA5: `adc_cs_n` low for 68 cycles; exactly 8 `adc_sclk` pulses of 8-cycle period; `adc_data`=8'hA5 together with a 1-cycle `sig` at T0+68.
- `en` held high, model returns 8'h50 then 8'h0F: `sig` pulses exactly 169 cycles apart; `adc_data` reads 8'h50, then 8'h0F; `adc_data` stable between strobes.
- CLK_DIV=1, CONV_GAP=1, sample 8'hFF then 8'h00: `adc_sclk` pulse period is 2 cycles; `sig` pulses 19 cycles apart; values are captured exactly.
- `en` dropped at T0+20 (defaults), sample 8'h3C: conversion completes, `sig` fires at T0+68 with 8'h3C; afterwards the block stays in IDLE with `busy`=0 and `adc_cs_n`=1.
- `n_rst` asserted at T0+30, released 5 cycles later with `en`=1: outputs show reset values during reset; no `sig` for the aborted sample; the next full conversion delivers the correct value.
- Downstream check: feed `sig`/`adc_data` into the comparator/counter with alternating samples 8'h60 and 8'h30 over 40 conversions: counter increments only on the 8'h60 samples and saturates at 4'hF.

Source files
------------

// File: rtl/adc_serial_reader.sv
// Serial ADC front end: drives chip-select and serial clock of an 8-bit
// serial-output ADC, shifts one sample in MSB-first and strobes it out.
module adc_serial_reader #(
    parameter int CLK_DIV  = 4,
    parameter int CONV_GAP = 100
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic       adc_sdo,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [7:0] adc_data,
    output logic       sig,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        GAP
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CONV_GAP - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [3:0]  edge_cnt, edge_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        cs_n_nxt, sclk_nxt, sig_nxt;
    logic [7:0]  data_nxt;
    logic        div_done;

    assign div_done = (cnt == DIV_LAST);
    assign busy     = (state != IDLE);

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path leaves one unassigned and infers a latch.
        state_nxt    = state;
        cnt_nxt      = cnt + 16'd1;
        edge_cnt_nxt = edge_cnt;
        shreg_nxt    = shreg;
        cs_n_nxt     = adc_cs_n;
        sclk_nxt     = adc_sclk;
        data_nxt     = adc_data;
        sig_nxt      = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    state_nxt = SETUP;
                    cs_n_nxt  = 1'b0;
                end
            end
            SETUP: begin
                // Leaving SETUP is the first rising sclk edge, so bit 7 is captured here.
                if (div_done) begin
                    state_nxt    = SHIFT;
                    cnt_nxt      = '0;
                    sclk_nxt     = 1'b1;
                    shreg_nxt    = {shreg[6:0], adc_sdo};
                    edge_cnt_nxt = 4'd1;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    cnt_nxt  = '0;
                    sclk_nxt = ~adc_sclk;
                    if (!adc_sclk) begin
                        shreg_nxt = {shreg[6:0], adc_sdo};
                    end
                    // edge_cnt holds edges already issued; 15 means this is the final falling edge.
                    if (edge_cnt == 4'd15) begin
                        state_nxt    = DONE;
                        edge_cnt_nxt = '0;
                    end else begin
                        edge_cnt_nxt = edge_cnt + 4'd1;
                    end
                end
            end
            DONE: begin
                if (div_done) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    cs_n_nxt  = 1'b1;
                    data_nxt  = shreg;
                    sig_nxt   = 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            shreg    <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            adc_data <= '0;
            sig      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            edge_cnt <= edge_cnt_nxt;
            shreg    <= shreg_nxt;
            adc_cs_n <= cs_n_nxt;
            adc_sclk <= sclk_nxt;
            adc_data <= data_nxt;
            sig      <= sig_nxt;
        end
    end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: one default instance and one fast instance
// (CLK_DIV=1, CONV_GAP=1), each fed by a behavioural ADC, with a sample scoreboard.
module tb_adc_serial_reader;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       en_a, en_b;
    logic       sdo_a, sdo_b;
    logic       cs_n_a, cs_n_b, sclk_a, sclk_b, sig_a, sig_b, busy_a, busy_b;
    logic [7:0] data_a, data_b;

    always #5 clk = ~clk;

    adc_serial_reader dut_a (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en_a),
        .adc_sdo  (sdo_a),
        .adc_cs_n (cs_n_a),
        .adc_sclk (sclk_a),
        .adc_data (data_a),
        .sig      (sig_a),
        .busy     (busy_a)
    );

    adc_serial_reader #(.CLK_DIV(1), .CONV_GAP(1)) dut_b (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en_b),
        .adc_sdo  (sdo_b),
        .adc_cs_n (cs_n_b),
        .adc_sclk (sclk_b),
        .adc_data (data_b),
        .sig      (sig_b),
        .busy     (busy_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Samples served by the ADC models, and samples expected at sig.
    bit [7:0] mdl_a[$], mdl_b[$], exp_a[$], exp_b[$];

    // ADC model: new word on chip-select fall, MSB presented first,
    // next bit presented after each falling sclk.
    logic [7:0] tx_a = 8'h00, tx_b = 8'h00;
    logic [2:0] bit_a = 3'd7, bit_b = 3'd7;
    assign sdo_a = tx_a[bit_a];
    assign sdo_b = tx_b[bit_b];

    always @(negedge cs_n_a) if (mdl_a.size() > 0) tx_a = mdl_a.pop_front();
    always @(negedge cs_n_b) if (mdl_b.size() > 0) tx_b = mdl_b.pop_front();

    always @(negedge sclk_a or posedge cs_n_a) begin
        if (cs_n_a) bit_a <= 3'd7;
        else        bit_a <= bit_a - 3'd1;
    end
    always @(negedge sclk_b or posedge cs_n_b) begin
        if (cs_n_b) bit_b <= 3'd7;
        else        bit_b <= bit_b - 3'd1;
    end

    // Downstream comparator/counter model on the fast instance.
    localparam logic [7:0] THRESH = 8'h50;
    logic [3:0] hits = 4'h0;
    logic       hits_clr = 1'b0;

    always @(negedge clk) begin
        if (sig_a) begin
            if (exp_a.size() == 0) check("sig_a_unexpected", 32'(sig_a), 32'd0);
            else                   check("data_a", 32'(data_a), 32'(exp_a.pop_front()));
        end
        if (sig_b) begin
            if (exp_b.size() == 0) check("sig_b_unexpected", 32'(sig_b), 32'd0);
            else                   check("data_b", 32'(data_b), 32'(exp_b.pop_front()));
        end
        if (hits_clr) hits <= 4'h0;
        else if (sig_b && data_b > THRESH && hits != 4'hF) hits <= hits + 4'h1;
    end

    task automatic push_a(input bit [7:0] v, input bit expect_it);
        mdl_a.push_back(v);
        if (expect_it) exp_a.push_back(v);
    endtask

    task automatic push_b(input bit [7:0] v);
        mdl_b.push_back(v);
        exp_b.push_back(v);
    endtask

    // Observation window. Called at a negedge; raises en, so the next posedge
    // is T0 and index i is the sample taken after edge T0+i.
    int w_sig_cnt, w_sig0, w_sig1, w_rises, w_rise0, w_rise1, w_cs_low, w_changes;

    task automatic run_window(input bit sel, input int n, input int drop_at);
        logic       cs, sc, sg, prev_sclk;
        logic [7:0] d, prev_data;
        w_sig_cnt = 0; w_sig0 = -1; w_sig1 = -1;
        w_rises = 0;   w_rise0 = -1; w_rise1 = -1;
        w_cs_low = 0;  w_changes = 0;
        prev_sclk = 1'b0;
        prev_data = sel ? data_b : data_a;
        if (sel) en_b = 1'b1; else en_a = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cs = sel ? cs_n_b : cs_n_a;
            sc = sel ? sclk_b : sclk_a;
            sg = sel ? sig_b  : sig_a;
            d  = sel ? data_b : data_a;
            if (!cs) w_cs_low++;
            if (sc && !prev_sclk) begin
                if (w_rises == 0) w_rise0 = i;
                else if (w_rises == 1) w_rise1 = i;
                w_rises++;
            end
            if (sg) begin
                if (w_sig_cnt == 0) w_sig0 = i;
                else if (w_sig_cnt == 1) w_sig1 = i;
                w_sig_cnt++;
            end
            if (d != prev_data && !sg) w_changes++;
            prev_sclk = sc;
            prev_data = d;
            if (i == drop_at) begin
                if (sel) en_b = 1'b0; else en_a = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        int k = 0;
        while ((sel ? busy_b : busy_a) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(sel ? busy_b : busy_a), 32'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n_a", 32'(cs_n_a), 32'd1);
        check("rst_sclk_a", 32'(sclk_a), 32'd0);
        check("rst_data_a", 32'(data_a), 32'd0);
        check("rst_sig_a",  32'(sig_a),  32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_cs_n_b", 32'(cs_n_b), 32'd1);
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_busy_a", 32'(busy_a), 32'd0);

        // Single conversion, defaults.
        push_a(8'hA5, 1'b1);
        run_window(1'b0, 120, 1);
        check("t1_cs_low",   32'(w_cs_low), 32'd68);
        check("t1_rises",    32'(w_rises),  32'd8);
        check("t1_rise0",    32'(w_rise0),  32'd4);
        check("t1_sclk_per", 32'(w_rise1 - w_rise0), 32'd8);
        check("t1_sig_cnt",  32'(w_sig_cnt), 32'd1);
        check("t1_sig_at",   32'(w_sig0),   32'd68);
        wait_idle(1'b0, "t1_idle");

        // Back-to-back conversions, defaults.
        push_a(8'h50, 1'b1);
        push_a(8'h0F, 1'b1);
        run_window(1'b0, 260, 240);
        check("t2_sig_cnt", 32'(w_sig_cnt), 32'd2);
        check("t2_sig_at",  32'(w_sig0),    32'd68);
        check("t2_period",  32'(w_sig1 - w_sig0), 32'd169);
        check("t2_stable",  32'(w_changes), 32'd0);
        wait_idle(1'b0, "t2_idle");

        // Fast instance, minimum divider and gap.
        push_b(8'hFF);
        push_b(8'h00);
        run_window(1'b1, 45, 36);
        check("t3_sig_cnt",  32'(w_sig_cnt), 32'd2);
        check("t3_sig_at",   32'(w_sig0),    32'd17);
        check("t3_period",   32'(w_sig1 - w_sig0), 32'd19);
        check("t3_rise0",    32'(w_rise0),   32'd1);
        check("t3_sclk_per", 32'(w_rise1 - w_rise0), 32'd2);
        check("t3_rises",    32'(w_rises),   32'd16);
        check("t3_stable",   32'(w_changes), 32'd0);
        wait_idle(1'b1, "t3_idle");

        // en dropped mid-conversion: it still completes, then stays idle.
        push_a(8'h3C, 1'b1);
        run_window(1'b0, 200, 20);
        check("t4_sig_cnt", 32'(w_sig_cnt), 32'd1);
        check("t4_sig_at",  32'(w_sig0),    32'd68);
        check("t4_busy",    32'(busy_a),    32'd0);
        check("t4_cs_n",    32'(cs_n_a),    32'd1);

        // Reset at T0+30: aborted sample never reaches the scoreboard.
        push_a(8'hC3, 1'b0);
        push_a(8'h96, 1'b1);
        en_a = 1'b1;
        repeat (31) @(negedge clk);
        check("t5_busy_pre", 32'(busy_a), 32'd1);
        n_rst = 1'b0;
        #1;
        check("t5_rst_cs_n", 32'(cs_n_a), 32'd1);
        check("t5_rst_sclk", 32'(sclk_a), 32'd0);
        check("t5_rst_data", 32'(data_a), 32'd0);
        check("t5_rst_sig",  32'(sig_a),  32'd0);
        check("t5_rst_busy", 32'(busy_a), 32'd0);
        repeat (5) @(negedge clk);
        check("t5_rst_hold", 32'(cs_n_a), 32'd1);
        n_rst = 1'b1;
        run_window(1'b0, 100, 1);
        check("t5_sig_cnt", 32'(w_sig_cnt), 32'd1);
        check("t5_sig_at",  32'(w_sig0),    32'd68);
        wait_idle(1'b0, "t5_idle");

        // Downstream counter: alternating 60/30 over 40 conversions.
        hits_clr = 1'b1;
        @(negedge clk);
        hits_clr = 1'b0;
        for (int i = 0; i < 40; i++) push_b((i % 2 == 0) ? 8'h60 : 8'h30);
        run_window(1'b1, 770, 758);
        check("t6_sig_cnt", 32'(w_sig_cnt), 32'd40);
        check("t6_hits",    32'(hits),      32'hF);
        wait_idle(1'b1, "t6_idle");

        check("exp_a_left", 32'(exp_a.size()), 32'd0);
        check("exp_b_left", 32'(exp_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
